mips_multicycle_control: RTL and testbench

Parametrised multi-cycle control unit for the MIPS datapath. It supersedes the single-cycle combinational decoder. A Moore/Mealy FSM sequences each instruction through fetch, decode, execute, memory and write-back cycles. It stalls on memory wait states, flags illegal opcodes and counts retired instructions. It sits between the instruction register (opcode/funct) and the datapath muxes, register file, ALU and memory port.

---
 rtl/mips_multicycle_control_pkg.sv | 31 +++
 rtl/mips_multicycle_control_if.sv | 38 +++
 rtl/mips_multicycle_control_retire_counter.sv | 16 +
 rtl/mips_multicycle_control.sv | 165 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// rtl/mips_multicycle_control_pkg.sv - shared states, opcodes, ALU codes and mux encodings
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWRITE,
    ST_RTEXEC, ST_RTWB, ST_ADDIEXEC, ST_ADDIWB, ST_BRANCH, ST_JUMP, ST_EXC
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_SLT = 6'b101010;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// rtl/mips_multicycle_control_if.sv - control unit to datapath signal bundle
interface mips_multicycle_control_if #(
  parameter int ALU_SEL_W = 6,
  parameter int CNT_W     = 32
);
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic [1:0]           pc_src;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 regsel;
  logic                 datasource;
  logic                 reg_write;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [ALU_SEL_W-1:0] alu_sel;
  logic                 illegal_op;
  logic [CNT_W-1:0]     instr_count;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           regsel, datasource, reg_write, alu_src_a, alu_src_b, alu_sel,
           illegal_op, instr_count
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
           regsel, datasource, reg_write, alu_src_a, alu_src_b, alu_sel,
           illegal_op, instr_count
  );
endinterface

// File: rtl/mips_multicycle_control_retire_counter.sv
// rtl/mips_multicycle_control_retire_counter.sv - retired-instruction counter, wraps modulo 2^CNT_W
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (inc_en) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multi-cycle MIPS control FSM with wait states and retire count
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_SEL_W   = 6,
  parameter int CNT_W       = 32,
  parameter int MEM_WAIT_EN = 1
) (
  input logic                       clk,
  input logic                       rst_n,
  mips_multicycle_control_if.master bus
);

  state_t     state, state_nx;
  logic       is_sw;
  logic       rdy;
  logic       inc;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       regsel, datasource, reg_write, alu_src_a, illegal_op;
  logic [1:0] pc_src, alu_src_b;
  logic [5:0] alu_code;

  assign rdy = (MEM_WAIT_EN != 0) ? bus.mem_ready : 1'b1;

  // lw/sw is resolved in DECODE so MEMADR does not depend on opcode staying valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      is_sw <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_DECODE) is_sw <= (bus.opcode == OP_SW);
    end
  end

  always_comb begin
    state_nx      = state;
    inc           = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    regsel        = 1'b0;
    datasource    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_RT;
    alu_code      = 6'b0;
    illegal_op    = 1'b0;
    unique case (state)
      ST_IDLE: state_nx = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        alu_code  = ALU_ADD;
        if (rdy) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        alu_code  = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_nx = ST_MEMADR;
          OP_RTYPE:     state_nx = ST_RTEXEC;
          OP_ADDI:      state_nx = ST_ADDIEXEC;
          OP_BEQ:       state_nx = ST_BRANCH;
          OP_J:         state_nx = ST_JUMP;
          default:      state_nx = ST_EXC;
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_code  = ALU_ADD;
        state_nx  = is_sw ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (rdy) state_nx = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        datasource = 1'b1;
        inc        = 1'b1;
        state_nx   = ST_FETCH;
      end
      ST_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (rdy) begin
          inc      = 1'b1;
          state_nx = ST_FETCH;
        end
      end
      ST_RTEXEC: begin
        alu_src_a = 1'b1;
        alu_code  = bus.funct;
        state_nx  = ST_RTWB;
      end
      ST_RTWB: begin
        reg_write = 1'b1;
        regsel    = 1'b1;
        inc       = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_code  = ALU_ADD;
        state_nx  = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        reg_write = 1'b1;
        inc       = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_code      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
        inc           = 1'b1;
        state_nx      = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        inc      = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_EXC:  illegal_op = 1'b1;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.pc_src        = pc_src;
  assign bus.iord          = iord;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.regsel        = regsel;
  assign bus.datasource    = datasource;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_sel       = ALU_SEL_W'(alu_code);
  assign bus.illegal_op    = illegal_op;

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (inc),
    .count  (bus.instr_count)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - directed checks of state outputs, wait states, retire count, reset
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_control_if #(.ALU_SEL_W(6), .CNT_W(32)) bus ();
  mips_multicycle_control_if #(.ALU_SEL_W(6), .CNT_W(2))  bus2 ();

  mips_multicycle_control #(.ALU_SEL_W(6), .CNT_W(32), .MEM_WAIT_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mips_multicycle_control #(.ALU_SEL_W(6), .CNT_W(2), .MEM_WAIT_EN(0)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  // {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
  //  regsel, datasource, reg_write, alu_src_a, alu_src_b, alu_sel, illegal_op}
  logic [20:0] ctl;
  assign ctl = {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.iord, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.regsel, bus.datasource, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_sel, bus.illegal_op};

  function automatic logic [20:0] mk(input logic pw, input logic pwc, input logic [1:0] pcs,
                                     input logic io, input logic mr, input logic mw,
                                     input logic irw, input logic rs, input logic ds,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [5:0] alu, input logic ill);
    return {pw, pwc, pcs, io, mr, mw, irw, rs, ds, rw, asa, asb, alu, ill};
  endfunction

  logic [20:0] e_zero, e_fwait, e_frdy, e_dec, e_madr, e_mrd, e_mwb, e_mwr;
  logic [20:0] e_rtx_sub, e_rtwb, e_awb, e_br, e_jmp, e_exc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rdy, input logic [20:0] exp);
    @(negedge clk);
    bus.mem_ready = rdy;
    #1;
    check(tag, 32'(ctl), 32'(exp));
  endtask

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input int waits);
    bus.opcode = op;
    bus.funct  = fn;
    for (int i = 0; i < waits; i++) cyc("fetch_wait", 1'b0, e_fwait);
    cyc("fetch", 1'b1, e_frdy);
  endtask

  initial begin
    e_zero    = '0;
    e_fwait   = mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 6'b100000, 0);
    e_frdy    = mk(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 6'b100000, 0);
    e_dec     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 6'b100000, 0);
    e_madr    = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 6'b100000, 0);
    e_mrd     = mk(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 6'b000000, 0);
    e_mwb     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 6'b000000, 0);
    e_mwr     = mk(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 6'b000000, 0);
    e_rtx_sub = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 6'b100010, 0);
    e_rtwb    = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 6'b000000, 0);
    e_awb     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 6'b000000, 0);
    e_br      = mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 6'b100010, 0);
    e_jmp     = mk(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 6'b000000, 0);
    e_exc     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 6'b000000, 1);

    rst_n = 1'b0;
    rst2_n = 1'b0;
    bus.opcode = 6'b100011;
    bus.funct = 6'b0;
    bus.mem_ready = 1'b0;
    bus2.opcode = 6'b000010;
    bus2.funct = 6'b0;
    bus2.mem_ready = 1'b0;
    #1;
    check("reset_ctl", 32'(ctl), 32'(e_zero));
    check("reset_cnt", bus.instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_ctl", 32'(ctl), 32'(e_zero));

    // lw, no wait states
    fetch(6'b100011, 6'b0, 0);
    cyc("lw_decode", 1'b1, e_dec);
    cyc("lw_memadr", 1'b1, e_madr);
    cyc("lw_memread", 1'b1, e_mrd);
    cyc("lw_memwb", 1'b1, e_mwb);
    check("lw_cnt_before", bus.instr_count, 32'd0);

    // R-type sub, with two fetch wait states
    fetch(6'b000000, 6'b100010, 2);
    check("lw_cnt", bus.instr_count, 32'd1);
    cyc("rt_decode", 1'b1, e_dec);
    cyc("rt_exec", 1'b1, e_rtx_sub);
    cyc("rt_wb", 1'b1, e_rtwb);

    // sw with 3 wait cycles in MEMWRITE
    fetch(6'b101011, 6'b0, 0);
    check("rt_cnt", bus.instr_count, 32'd2);
    cyc("sw_decode", 1'b1, e_dec);
    cyc("sw_memadr", 1'b1, e_madr);
    for (int i = 0; i < 3; i++) begin
      cyc("sw_memwrite_wait", 1'b0, e_mwr);
      check("sw_cnt_wait", bus.instr_count, 32'd2);
    end
    cyc("sw_memwrite", 1'b1, e_mwr);

    // beq then j
    fetch(6'b000100, 6'b0, 0);
    check("sw_cnt", bus.instr_count, 32'd3);
    cyc("beq_decode", 1'b1, e_dec);
    cyc("beq_branch", 1'b1, e_br);
    fetch(6'b000010, 6'b0, 0);
    cyc("j_decode", 1'b1, e_dec);
    cyc("j_jump", 1'b1, e_jmp);

    // addi
    fetch(6'b001000, 6'b0, 0);
    check("beq_j_cnt", bus.instr_count, 32'd5);
    cyc("addi_decode", 1'b1, e_dec);
    cyc("addi_exec", 1'b1, e_madr);
    cyc("addi_wb", 1'b1, e_awb);

    // illegal opcode sticks in EXC
    fetch(6'b111111, 6'b0, 0);
    check("addi_cnt", bus.instr_count, 32'd6);
    cyc("ill_decode", 1'b1, e_dec);
    for (int i = 0; i < 3; i++) cyc("exc", 1'b1, e_exc);
    check("exc_cnt", bus.instr_count, 32'd6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("exc_reset_ctl", 32'(ctl), 32'(e_zero));
    check("exc_reset_cnt", bus.instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("exc_idle_ctl", 32'(ctl), 32'(e_zero));

    // j to get a nonzero count, then lw aborted mid-MEMREAD
    fetch(6'b000010, 6'b0, 0);
    cyc("j2_decode", 1'b1, e_dec);
    cyc("j2_jump", 1'b1, e_jmp);
    fetch(6'b100011, 6'b0, 0);
    check("j2_cnt", bus.instr_count, 32'd1);
    cyc("lw2_decode", 1'b1, e_dec);
    cyc("lw2_memadr", 1'b1, e_madr);
    cyc("lw2_memread_wait", 1'b0, e_mrd);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ctl", 32'(ctl), 32'(e_zero));
    check("abort_cnt", bus.instr_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2-bit counter, no wait states, mem_ready tied low: back-to-back j
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("wrap_cnt_1", 32'(bus2.instr_count), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("wrap_cnt_2", 32'(bus2.instr_count), 32'd2);
    repeat (3) @(negedge clk);
    #1;
    check("wrap_cnt_3", 32'(bus2.instr_count), 32'd3);
    repeat (3) @(negedge clk);
    #1;
    check("wrap_cnt_0", 32'(bus2.instr_count), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("wrap_cnt_1b", 32'(bus2.instr_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
